// File: rtl/pm_pkg.sv
// ---------------------------------------------------------------------------
// pm_pkg
//   Shared definitions for the router power-management blocks.
//   - req_state_e : state of the upstream wake requester (1-bit encoding).
//   - pm_state_e  : state constants of the downstream router power manager.
//   - WAKE_UP_LATENCY : default downstream wake-up latency in cycles. Any
//     requester timeout must exceed it, or a healthy wake gets flagged.
// ---------------------------------------------------------------------------
package pm_pkg;

  typedef enum logic {
    RUN = 1'b0,
    REQ = 1'b1
  } req_state_e;

  typedef enum logic [1:0] {
    ON       = 2'd0,
    WAKE_UP  = 2'd1,
    CLK_GATE = 2'd2,
    PWR_GATE = 2'd3
  } pm_state_e;

  localparam int unsigned WAKE_UP_LATENCY = 200;

endpackage : pm_pkg

// File: rtl/flit_hold_buffer.sv
// ---------------------------------------------------------------------------
// flit_hold_buffer
//   One-entry valid/ready register with a stall input. A flit is accepted
//   only while the entry is empty and leaves only while it is full, so a
//   load and an unload never coincide (at most one flit per two cycles).
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_data    : upstream flit
//   in_ready            : entry empty, a flit can be accepted
//   out_valid/out_data  : buffered flit offered downstream (masked by stall)
//   out_ready           : downstream accepts the flit
//   stall               : holds the flit back without dropping it
//   buf_valid           : raw entry-occupied flag, independent of stall
// ---------------------------------------------------------------------------
module flit_hold_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  stall,
  output logic                  buf_valid
);

  logic load;
  logic unload;

  assign in_ready  = ~buf_valid;
  assign out_valid = buf_valid & ~stall;
  assign load      = in_valid & in_ready;
  assign unload    = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      // NOTE: the data register is reset even though buf_valid qualifies it;
      // out_data is visible at the port and must read 0 after reset.
      out_data  <= '0;
    end else begin
      if (load) begin
        buf_valid <= 1'b1;
        out_data  <= in_data;
      end else if (unload) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule : flit_hold_buffer

// File: rtl/power_wakeup_requester.sv
// ---------------------------------------------------------------------------
// power_wakeup_requester
//   Sits on a router output port in front of a link whose downstream router
//   may be clock- or power-gated. Outgoing flits are held in a one-entry
//   buffer; while the downstream reports signal_off the flit is stalled and
//   a registered wake request (request_to_on) is raised. The request is held
//   for at least REQ_HOLD cycles and drops once the downstream is on, after
//   which the flit is released. Counts wake requests (saturating) and keeps
//   a sticky flag for a request that outlives WAKE_TIMEOUT cycles.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_data    : upstream flit          in_ready : buffer empty
//   out_valid/out_data  : flit to downstream     out_ready: downstream takes it
//   signal_off          : downstream is gated or still waking
//   request_to_on       : registered wake request to the downstream manager
//   active              : local activity, feeds this router's power manager
//   wake_count          : wake requests issued, saturating at all-ones
//   timeout_err         : sticky, a wake request exceeded WAKE_TIMEOUT
// ---------------------------------------------------------------------------
module power_wakeup_requester
  import pm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int WAKE_TIMEOUT = 255,
  parameter int REQ_HOLD     = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  signal_off,
  output logic                  request_to_on,
  output logic                  active,
  output logic [CNT_WIDTH-1:0]  wake_count,
  output logic                  timeout_err
);

  localparam int HOLD_W = 4;
  localparam int WAIT_W = $clog2(WAKE_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0]    HOLD_MAX  = HOLD_W'(REQ_HOLD - 1);
  localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(WAKE_TIMEOUT);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(WAKE_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  // Elaboration-time guards on the parameter ranges.
  if (REQ_HOLD < 1 || REQ_HOLD > 15) begin : g_bad_req_hold
    $error("REQ_HOLD must be in 1..15");
  end
  if (WAKE_TIMEOUT <= int'(WAKE_UP_LATENCY)) begin : g_bad_timeout
    $error("WAKE_TIMEOUT must exceed the downstream WAKE_UP_LATENCY");
  end

  req_state_e           state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [CNT_WIDTH-1:0] wake_count_d;
  logic                 timeout_d;
  logic                 buf_valid;
  logic                 stall;

  // The flit may only leave in RUN with the downstream reporting on; a
  // signal_off rising together with out_ready therefore blocks the transfer.
  assign stall = (state_q != RUN) | signal_off;

  flit_hold_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall     (stall),
    .buf_valid (buf_valid)
  );

  assign active        = in_valid | buf_valid;
  // The state flop itself is the registered request.
  assign request_to_on = (state_q == REQ);

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    hold_d       = hold_q;
    wait_d       = wait_q;
    wake_count_d = wake_count;
    timeout_d    = timeout_err;

    unique case (state_q)
      RUN: begin
        // Only a pending flit justifies a wake; a gated, idle link is fine.
        if (buf_valid && signal_off) begin
          state_d = REQ;
          hold_d  = '0;
          wait_d  = '0;
          if (wake_count != CNT_MAX) begin
            wake_count_d = wake_count + 1'b1;
          end
        end
      end

      REQ: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
        // Flag on the edge where wait_cnt becomes WAKE_TIMEOUT, so the flag
        // is visible exactly WAKE_TIMEOUT cycles after REQ entry.
        if (wait_q >= WAIT_LAST) timeout_d = 1'b1;
        // The hold check makes a one-cycle low glitch on signal_off early in
        // the request harmless: it cannot end REQ before the hold elapses.
        if (hold_q >= HOLD_MAX && !signal_off) begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      hold_q      <= '0;
      wait_q      <= '0;
      wake_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wait_q      <= wait_d;
      wake_count  <= wake_count_d;
      timeout_err <= timeout_d;
    end
  end

endmodule : power_wakeup_requester

// File: tb/tb_power_wakeup_requester.sv
// ---------------------------------------------------------------------------
// tb_power_wakeup_requester
//   Directed scenarios for the wake handshake followed by a randomized phase.
//   A transaction-level reference model (buffered flit, request start cycle,
//   elapsed-cycle arithmetic) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_power_wakeup_requester;

  localparam int DW = 32;
  localparam int WT = 255;
  localparam int RH = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          signal_off;
  logic          request_to_on;
  logic          active;
  logic [CW-1:0] wake_count;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  bit            m_full;
  logic [DW-1:0] m_data;
  bit            m_req;
  int            m_start;
  int            m_wakes;
  bit            m_to;

  // Scenario bookkeeping.
  int base, rise, first_ov, hi, to_cyc;
  bit flag_a, flag_b;

  always #5 clk = ~clk;

  power_wakeup_requester #(
    .DATA_WIDTH   (DW),
    .WAKE_TIMEOUT (WT),
    .REQ_HOLD     (RH),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .signal_off    (signal_off),
    .request_to_on (request_to_on),
    .active        (active),
    .wake_count    (wake_count),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_check();
    check("in_ready",      in_ready,      !m_full);
    check("active",        active,        in_valid | m_full);
    check("out_valid",     out_valid,     m_full && !m_req && !signal_off);
    check("out_data",      out_data,      m_data);
    check("request_to_on", request_to_on, m_req);
    check("wake_count",    wake_count,    m_wakes);
    check("timeout_err",   timeout_err,   m_to);
  endtask

  // Advances the model across the edge that ends cycle 'cyc'.
  task automatic model_advance();
    bit offered  = m_full && !m_req && !signal_off;
    bit was_full = m_full;
    if (reset) begin
      m_full = 0; m_data = '0; m_req = 0; m_wakes = 0; m_to = 0;
      return;
    end
    if (offered && out_ready) m_full = 0;
    else if (!m_full && in_valid) begin
      m_full = 1;
      m_data = in_data;
    end
    if (m_req) begin
      // Request has been high for (cyc - m_start + 1) cycles so far.
      if (cyc + 1 - m_start >= WT) m_to = 1;
      if (cyc - m_start + 1 >= RH && !signal_off) m_req = 0;
    end else if (was_full && signal_off) begin
      m_req   = 1;
      m_start = cyc + 1;
      if (m_wakes < 2**CW - 1) m_wakes++;
    end
  endtask

  // Called with inputs already driven for the current cycle; checks, then
  // moves to 1 time unit after the next rising edge.
  task automatic cycle();
    #1;
    model_check();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; out_ready = 1; signal_off = 0;
    cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = '0; out_ready = 1; signal_off = 0;
    m_full = 0; m_data = '0; m_req = 0; m_start = 0; m_wakes = 0; m_to = 0;
    @(posedge clk);
    #1;
    do_reset();

    // ---- 1: downstream on, flit passes with one cycle of latency ----
    do_reset();
    base = cyc;
    repeat (10) cycle();
    in_valid = 1; in_data = 32'hA5A5_0001;
    cycle();
    in_valid = 0;
    check("t1_out_valid_n1", out_valid, 1'b1);
    check("t1_out_data", out_data, 32'hA5A5_0001);
    flag_a = 0;
    repeat (20) begin
      flag_a |= request_to_on;
      cycle();
    end
    check("t1_no_request", flag_a, 1'b0);
    check("t1_wake_count", wake_count, 0);

    // ---- 2: power-gated downstream, wakes 199 cycles into the request ----
    do_reset();
    base = cyc; signal_off = 1;
    repeat (10) cycle();
    in_valid = 1; in_data = 32'hC0DE_0002;
    cycle();
    in_valid = 0;
    rise = -1; first_ov = -1; hi = 0;
    repeat (260) begin
      if (request_to_on && rise < 0) rise = cyc;
      if (request_to_on) hi++;
      signal_off = !(rise >= 0 && cyc >= rise + 199);
      #1;
      if (out_valid && first_ov < 0) begin
        first_ov = cyc;
        check("t2_out_data", out_data, 32'hC0DE_0002);
      end
      cycle();
    end
    check("t2_req_rise_cycle", rise, base + 12);
    check("t2_req_high_cycles", hi, 200);
    check("t2_out_valid_cycle", first_ov, rise + 200);
    check("t2_wake_count", wake_count, 1);

    // ---- 3: clock-gated downstream, on one cycle after the request ----
    do_reset();
    base = cyc; signal_off = 1;
    repeat (10) cycle();
    in_valid = 1; in_data = 32'h1234_0003;
    cycle();
    in_valid = 0;
    rise = -1; first_ov = -1; hi = 0;
    repeat (20) begin
      if (request_to_on && rise < 0) rise = cyc;
      if (request_to_on) hi++;
      signal_off = !(rise >= 0 && cyc >= rise + 1);
      #1;
      if (out_valid && first_ov < 0) begin
        first_ov = cyc;
        check("t3_out_data", out_data, 32'h1234_0003);
      end
      cycle();
    end
    check("t3_req_rise_cycle", rise, base + 12);
    check("t3_req_high_cycles", hi, RH);
    check("t3_out_valid_cycle", first_ov, rise + RH);

    // ---- 4: downstream never wakes, then reset pulsed mid-request ----
    do_reset();
    base = cyc; signal_off = 1;
    repeat (10) cycle();
    in_valid = 1; in_data = 32'h0BAD_0004;
    cycle();
    in_data = 32'hFFFF_0005;     // keeps offering a second flit
    rise = -1; to_cyc = -1; flag_a = 1; flag_b = 1;
    repeat (300) begin
      if (request_to_on && rise < 0) rise = cyc;
      if (timeout_err && to_cyc < 0) to_cyc = cyc;
      if (rise >= 0 && !request_to_on) flag_a = 0;
      if (in_ready) flag_b = 0;
      cycle();
    end
    check("t4_req_rise_cycle", rise, base + 12);
    check("t4_timeout_cycle", to_cyc, rise + WT);
    check("t4_req_held", flag_a, 1'b1);
    check("t4_in_ready_low", flag_b, 1'b1);
    reset = 1;
    cycle();
    reset = 0; in_valid = 0;
    check("t6_request_cleared", request_to_on, 1'b0);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_wake_count", wake_count, 0);
    check("t6_timeout_cleared", timeout_err, 1'b0);
    cycle();
    check("t6_no_rerequest", request_to_on, 1'b0);

    // ---- 5: signal_off rises together with out_valid & out_ready ----
    do_reset();
    base = cyc;
    repeat (10) cycle();
    in_valid = 1; in_data = 32'h5EED_0006;
    cycle();
    in_valid = 0; signal_off = 1; out_ready = 1;
    #1;
    check("t5_transfer_blocked", out_valid, 1'b0);
    cycle();
    check("t5_flit_retained", in_ready, 1'b0);
    check("t5_req_entered", request_to_on, 1'b1);
    repeat (5) cycle();
    signal_off = 0;
    flag_a = 0;
    repeat (10) begin
      #1;
      if (out_valid && !flag_a) begin
        flag_a = 1;
        check("t5_same_data", out_data, 32'h5EED_0006);
      end
      cycle();
    end
    check("t5_delivered", flag_a, 1'b1);
    check("t5_wake_count", wake_count, 1);

    // ---- randomized traffic and power behaviour ----
    do_reset();
    repeat (3000) begin
      reset    = ($urandom_range(0, 499) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) signal_off = ~signal_off;
      cycle();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_power_wakeup_requester
